// File: rtl/debug_mode_ctrl_if.sv
// Core-side bundle of the debug-mode controller.
// The master modport is the pipeline/CSR side; the slave modport is the controller.
interface debug_mode_ctrl_if;
    logic        debug_req_i;
    logic        ebreak_i;
    logic        commit_valid_i;
    logic        dret_i;
    logic        flush_ack_i;
    logic [1:0]  priv_lvl_i;
    logic        dcsr_we_i;
    logic [31:0] dcsr_wdata_i;
    logic        flush_req_o;
    logic        set_debug_pc_o;
    logic        resume_o;
    logic        debug_mode_q_o;
    logic        mprven_o;
    logic [1:0]  dcsr_prv_o;
    logic [31:0] dcsr_o;
    logic        flush_timeout_o;

    modport master (
        output debug_req_i, ebreak_i, commit_valid_i, dret_i, flush_ack_i,
               priv_lvl_i, dcsr_we_i, dcsr_wdata_i,
        input  flush_req_o, set_debug_pc_o, resume_o, debug_mode_q_o,
               mprven_o, dcsr_prv_o, dcsr_o, flush_timeout_o
    );

    modport slave (
        input  debug_req_i, ebreak_i, commit_valid_i, dret_i, flush_ack_i,
               priv_lvl_i, dcsr_we_i, dcsr_wdata_i,
        output flush_req_o, set_debug_pc_o, resume_o, debug_mode_q_o,
               mprven_o, dcsr_prv_o, dcsr_o, flush_timeout_o
    );
endinterface

// File: rtl/debug_mode_ctrl.sv
// Debug-mode entry/exit sequencer owning dcsr (halt, flush, debug PC redirect, dret resume).
// Latency: entry event -> flush_req next cycle; ack/timeout -> halt next cycle; dret -> 1-cycle resume.
// Backpressure: holds flush_req until flush_ack or FLUSH_TIMEOUT cycles elapse, then forces halt.
module debug_mode_ctrl #(
    parameter int XDEBUGVER     = 4,
    parameter int FLUSH_TIMEOUT = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    debug_mode_ctrl_if.slave  dbg
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT, RESUME} state_t;

    localparam logic [31:0] DCSR_WMASK = 32'h0000_BE17;
    localparam logic [31:0] DCSR_RST   = {4'(XDEBUGVER), 26'h0, 2'b11};
    localparam logic [7:0]  CNT_LAST   = 8'(FLUSH_TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] dcsr_q;
    logic [7:0]  cnt_q;
    logic        flush_req_q, set_debug_pc_q, resume_q, debug_mode_q, timeout_q;

    logic        ebreak_en;
    logic        entry_evt;
    logic [2:0]  entry_cause;
    logic [31:0] dcsr_wr;

    // ebreak only traps to debug when the ebreak{m,s,u} bit for the current privilege is set
    always_comb begin
        ebreak_en = 1'b0;
        case (dbg.priv_lvl_i)
            2'b11:   ebreak_en = dcsr_q[15];
            2'b01:   ebreak_en = dcsr_q[13];
            2'b00:   ebreak_en = dcsr_q[12];
            default: ebreak_en = 1'b0;
        endcase
    end

    always_comb begin
        entry_evt   = 1'b1;
        entry_cause = 3'd0;
        if (dbg.ebreak_i && ebreak_en)                entry_cause = 3'd1;
        else if (dbg.debug_req_i)                     entry_cause = 3'd3;
        else if (dcsr_q[2] && dbg.commit_valid_i)     entry_cause = 3'd4;
        else                                          entry_evt   = 1'b0;
    end

    // prv=2'b10 is not a legal privilege and is coerced to M
    always_comb begin
        dcsr_wr = (dcsr_q & ~DCSR_WMASK) | (dbg.dcsr_wdata_i & DCSR_WMASK);
        if (dcsr_wr[1:0] == 2'b10) dcsr_wr[1:0] = 2'b11;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            dcsr_q         <= DCSR_RST;
            cnt_q          <= 8'd0;
            flush_req_q    <= 1'b0;
            set_debug_pc_q <= 1'b0;
            resume_q       <= 1'b0;
            debug_mode_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            set_debug_pc_q <= 1'b0;
            resume_q       <= 1'b0;
            case (state_q)
                RUN: begin
                    if (entry_evt) begin
                        dcsr_q[8:6] <= entry_cause;
                        dcsr_q[1:0] <= dbg.priv_lvl_i;
                        cnt_q       <= 8'd0;
                        flush_req_q <= 1'b1;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (dbg.flush_ack_i || cnt_q == CNT_LAST) begin
                        if (!dbg.flush_ack_i) timeout_q <= 1'b1;
                        flush_req_q    <= 1'b0;
                        set_debug_pc_q <= 1'b1;
                        debug_mode_q   <= 1'b1;
                        state_q        <= HALT;
                    end
                end
                HALT: begin
                    if (dbg.dcsr_we_i) dcsr_q <= dcsr_wr;
                    if (dbg.dret_i) begin
                        resume_q <= 1'b1;
                        state_q  <= RESUME;
                    end
                end
                RESUME: begin
                    debug_mode_q <= 1'b0;
                    state_q      <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign dbg.flush_req_o     = flush_req_q;
    assign dbg.set_debug_pc_o  = set_debug_pc_q;
    assign dbg.resume_o        = resume_q;
    assign dbg.debug_mode_q_o  = debug_mode_q;
    assign dbg.mprven_o        = dcsr_q[4];
    assign dbg.dcsr_prv_o      = dcsr_q[1:0];
    assign dbg.dcsr_o          = dcsr_q;
    assign dbg.flush_timeout_o = timeout_q;
endmodule

// File: tb/tb_debug_mode_ctrl.sv
// Directed bench for debug_mode_ctrl: entry priority, flush ack/timeout, dcsr write masking, step, reset.
module tb_debug_mode_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    debug_mode_ctrl_if dbg_if ();

    debug_mode_ctrl #(.XDEBUGVER(4), .FLUSH_TIMEOUT(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .dbg   (dbg_if)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_halt(input logic [1:0] priv, input logic req, input logic ebk);
        dbg_if.priv_lvl_i  = priv;
        dbg_if.debug_req_i = req;
        dbg_if.ebreak_i    = ebk;
        tick();
        dbg_if.debug_req_i = 1'b0;
        dbg_if.ebreak_i    = 1'b0;
        check("entry_flush_req", 32'(dbg_if.flush_req_o), 32'd1);
        dbg_if.flush_ack_i = 1'b1;
        tick();
        dbg_if.flush_ack_i = 1'b0;
        check("entry_debug_mode", 32'(dbg_if.debug_mode_q_o), 32'd1);
    endtask

    // dcsr write plus dret in the same cycle, then walk through the one RESUME cycle
    task automatic write_and_resume(input logic [31:0] wdata, input logic [31:0] exp_dcsr);
        dbg_if.dcsr_we_i    = 1'b1;
        dbg_if.dcsr_wdata_i = wdata;
        dbg_if.dret_i       = 1'b1;
        tick();
        dbg_if.dcsr_we_i = 1'b0;
        dbg_if.dret_i    = 1'b0;
        check("resume_pulse", 32'(dbg_if.resume_o), 32'd1);
        check("resume_dbg_mode", 32'(dbg_if.debug_mode_q_o), 32'd1);
        check("resume_dcsr", dbg_if.dcsr_o, exp_dcsr);
        tick();
        check("run_resume_low", 32'(dbg_if.resume_o), 32'd0);
        check("run_dbg_mode", 32'(dbg_if.debug_mode_q_o), 32'd0);
    endtask

    initial begin
        dbg_if.debug_req_i    = 1'b0;
        dbg_if.ebreak_i       = 1'b0;
        dbg_if.commit_valid_i = 1'b0;
        dbg_if.dret_i         = 1'b0;
        dbg_if.flush_ack_i    = 1'b0;
        dbg_if.priv_lvl_i     = 2'b11;
        dbg_if.dcsr_we_i      = 1'b0;
        dbg_if.dcsr_wdata_i   = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_dcsr", dbg_if.dcsr_o, 32'h4000_0003);
        check("rst_dbg_mode", 32'(dbg_if.debug_mode_q_o), 32'd0);
        check("rst_mprven", 32'(dbg_if.mprven_o), 32'd0);
        check("rst_pulses", {29'd0, dbg_if.flush_req_o, dbg_if.set_debug_pc_o, dbg_if.resume_o}, 32'd0);
        check("rst_timeout", 32'(dbg_if.flush_timeout_o), 32'd0);

        // haltreq at U-mode, ack on the third FLUSH cycle
        dbg_if.priv_lvl_i  = 2'b00;
        dbg_if.debug_req_i = 1'b1;
        tick();
        dbg_if.debug_req_i = 1'b0;
        check("hreq_flush_req", 32'(dbg_if.flush_req_o), 32'd1);
        tick();
        tick();
        check("hreq_still_flush", 32'(dbg_if.flush_req_o), 32'd1);
        dbg_if.flush_ack_i = 1'b1;
        tick();
        dbg_if.flush_ack_i = 1'b0;
        check("hreq_set_pc", 32'(dbg_if.set_debug_pc_o), 32'd1);
        check("hreq_dbg_mode", 32'(dbg_if.debug_mode_q_o), 32'd1);
        check("hreq_flush_low", 32'(dbg_if.flush_req_o), 32'd0);
        check("hreq_dcsr", dbg_if.dcsr_o, 32'h4000_00C0);
        check("hreq_prv", 32'(dbg_if.dcsr_prv_o), 32'd0);
        dbg_if.debug_req_i = 1'b1;
        tick();
        dbg_if.debug_req_i = 1'b0;
        check("halt_set_pc_pulse", 32'(dbg_if.set_debug_pc_o), 32'd0);
        check("halt_ignores_req", 32'(dbg_if.flush_req_o), 32'd0);

        // all-ones write: only writable bits change, cause 3 stays
        dbg_if.dcsr_we_i    = 1'b1;
        dbg_if.dcsr_wdata_i = 32'hFFFF_FFFF;
        tick();
        check("wr_ones_dcsr", dbg_if.dcsr_o, 32'h4000_BED7);
        check("wr_ones_mprven", 32'(dbg_if.mprven_o), 32'd1);
        dbg_if.dcsr_wdata_i = 32'h0000_8002;
        tick();
        dbg_if.dcsr_we_i = 1'b0;
        check("wr_prv_coerce", dbg_if.dcsr_o, 32'h4000_80C3);
        check("wr_mprven_clr", 32'(dbg_if.mprven_o), 32'd0);
        dbg_if.dret_i = 1'b1;
        tick();
        dbg_if.dret_i = 1'b0;
        check("dret_resume", 32'(dbg_if.resume_o), 32'd1);
        check("dret_dbg_mode", 32'(dbg_if.debug_mode_q_o), 32'd1);
        tick();
        check("dret_resume_low", 32'(dbg_if.resume_o), 32'd0);
        check("dret_run", 32'(dbg_if.debug_mode_q_o), 32'd0);

        dbg_if.dcsr_we_i    = 1'b1;
        dbg_if.dcsr_wdata_i = 32'hFFFF_FFFF;
        dbg_if.dret_i       = 1'b1;
        tick();
        dbg_if.dcsr_we_i = 1'b0;
        dbg_if.dret_i    = 1'b0;
        check("run_wr_ignored", dbg_if.dcsr_o, 32'h4000_80C3);
        check("run_dret_ignored", 32'(dbg_if.resume_o), 32'd0);

        // ebreakm=1: ebreak beats haltreq
        enter_halt(2'b11, 1'b1, 1'b1);
        check("prio_ebreak_cause", dbg_if.dcsr_o, 32'h4000_8043);
        write_and_resume(32'h0000_0003, 32'h4000_0043);

        // ebreakm=0: haltreq wins
        enter_halt(2'b11, 1'b1, 1'b1);
        check("prio_haltreq_cause", dbg_if.dcsr_o, 32'h4000_00C3);

        // single step: commit during RESUME is not counted
        dbg_if.dcsr_we_i    = 1'b1;
        dbg_if.dcsr_wdata_i = 32'h0000_0007;
        dbg_if.dret_i       = 1'b1;
        tick();
        dbg_if.dcsr_we_i = 1'b0;
        dbg_if.dret_i    = 1'b0;
        check("step_resume", 32'(dbg_if.resume_o), 32'd1);
        dbg_if.commit_valid_i = 1'b1;
        tick();
        dbg_if.commit_valid_i = 1'b0;
        check("step_resume_commit", 32'(dbg_if.flush_req_o), 32'd0);
        check("step_run", 32'(dbg_if.debug_mode_q_o), 32'd0);
        tick();
        check("step_idle", 32'(dbg_if.flush_req_o), 32'd0);
        dbg_if.commit_valid_i = 1'b1;
        tick();
        dbg_if.commit_valid_i = 1'b0;
        check("step_entry", 32'(dbg_if.flush_req_o), 32'd1);
        dbg_if.flush_ack_i = 1'b1;
        tick();
        dbg_if.flush_ack_i = 1'b0;
        check("step_cause", dbg_if.dcsr_o, 32'h4000_0107);
        write_and_resume(32'h0000_0003, 32'h4000_0103);

        // timeout: 16 FLUSH cycles without ack
        dbg_if.priv_lvl_i  = 2'b01;
        dbg_if.debug_req_i = 1'b1;
        tick();
        dbg_if.debug_req_i = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        check("to_flush16", 32'(dbg_if.flush_req_o), 32'd1);
        check("to_not_halted", 32'(dbg_if.debug_mode_q_o), 32'd0);
        tick();
        check("to_halt", 32'(dbg_if.debug_mode_q_o), 32'd1);
        check("to_set_pc", 32'(dbg_if.set_debug_pc_o), 32'd1);
        check("to_sticky_set", 32'(dbg_if.flush_timeout_o), 32'd1);
        check("to_dcsr", dbg_if.dcsr_o, 32'h4000_00C1);
        write_and_resume(32'h0000_0003, 32'h4000_00C3);
        check("to_sticky_run", 32'(dbg_if.flush_timeout_o), 32'd1);

        // reset while in FLUSH
        dbg_if.debug_req_i = 1'b1;
        tick();
        dbg_if.debug_req_i = 1'b0;
        check("rf_flush", 32'(dbg_if.flush_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rf_flush_low", 32'(dbg_if.flush_req_o), 32'd0);
        check("rf_timeout_clr", 32'(dbg_if.flush_timeout_o), 32'd0);
        check("rf_dcsr", dbg_if.dcsr_o, 32'h4000_0003);
        tick();
        check("rf_stay_run", {30'd0, dbg_if.flush_req_o, dbg_if.debug_mode_q_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
